// File: rtl/risc16_mem_arbiter.sv
// risc16_mem_arbiter: serialises the RISC16 core's data access and
// instruction fetch onto one single-ported, fixed-latency SRAM. The data
// access runs first. The core is stalled until both accesses have finished.
module risc16_mem_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] iaddr,
    input  logic          ioe,
    output logic [DW-1:0] idin,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] ddout,
    input  logic          doe,
    input  logic          dwe,
    output logic [DW-1:0] ddin,
    output logic          stall,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_oe,
    output logic          mem_we,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, DATA, INST, RELEASE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_STATES);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] iaddr_q, daddr_q;
    logic [DW-1:0] ddout_q;
    logic          ioe_q, doe_q, dwe_q;
    logic [DW-1:0] idin_q, ddin_q;
    logic          err_q;
    logic          last;

    assign last = (cnt_q == CNT_LAST);

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request snapshot, read-data capture and sticky conflict flag
    always_ff @(posedge clk) begin
        if (rst) begin
            iaddr_q <= '0;
            ioe_q   <= 1'b0;
            daddr_q <= '0;
            ddout_q <= '0;
            doe_q   <= 1'b0;
            dwe_q   <= 1'b0;
            idin_q  <= '0;
            ddin_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                iaddr_q <= iaddr;
                ioe_q   <= ioe;
                daddr_q <= daddr;
                ddout_q <= ddout;
                doe_q   <= doe;
                dwe_q   <= dwe;
                if (doe && dwe) begin
                    err_q <= 1'b1;
                end
            end
            // A conflicting doe+dwe request is a store, so it never loads ddin
            if (state_q == DATA && last && doe_q && !dwe_q) begin
                ddin_q <= mem_rdata;
            end
            if (state_q == INST && last) begin
                idin_q <= mem_rdata;
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (doe || dwe) begin
                    state_d = DATA;
                end else if (ioe) begin
                    state_d = INST;
                end else begin
                    state_d = RELEASE;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = ioe_q ? INST : RELEASE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            INST: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes and core stall, decoded from the current state
    always_comb begin
        stall     = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_oe    = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            DATA: begin
                mem_addr = daddr_q;
                if (dwe_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = ddout_q;
                end else begin
                    mem_oe = 1'b1;
                end
            end
            INST: begin
                mem_addr = iaddr_q;
                mem_oe   = 1'b1;
            end
            RELEASE: begin
                stall = 1'b0;
            end
            default: ;
        endcase
    end

    assign idin = idin_q;
    assign ddin = ddin_q;
    assign err  = err_q;

endmodule
